moving_average: RTL and testbench

//  Boxcar (moving-average) low-pass stage placed directly downstream of gain.

---
 rtl/moving_average_if.sv | 36 +++
 rtl/moving_average.sv | 131 +++++++++++++
 tb/tb_moving_average.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/moving_average_if.sv
// Sample stream interface for the moving_average stage.
//   master : upstream producer / consumer side (drives i_data, i_valid;
//            observes o_data, o_valid, o_primed)
//   slave  : the filter itself (consumes i_data, i_valid;
//            produces o_data, o_valid, o_primed)
// Signals:
//   i_data   signed input sample, qualified by i_valid
//   i_valid  1 = i_data is accepted this cycle (no backpressure)
//   o_data   signed window mean, registered
//   o_valid  one-cycle pulse: o_data has just been updated
//   o_primed high once a full window of samples has been accepted
interface moving_average_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] i_data;
  logic                         i_valid;
  logic signed [DATA_WIDTH-1:0] o_data;
  logic                         o_valid;
  logic                         o_primed;

  modport master (
    output i_data,
    output i_valid,
    input  o_data,
    input  o_valid,
    input  o_primed
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_data,
    output o_valid,
    output o_primed
  );
endinterface

// File: rtl/moving_average.sv
// Boxcar moving-average low-pass stage.
// Outputs the mean of the last 2**LOG2_TAPS accepted signed samples using a
// circular sample buffer and a running sum (one add and one subtract per
// sample, no multipliers). Latency is one cycle from accept to o_valid.
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  synchronous active-low reset
//   bus        moving_average_if.slave: i_data/i_valid in,
//              o_data/o_valid/o_primed out (all outputs registered)
module moving_average #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  moving_average_if.slave  bus
);

  localparam int N     = 1 << LOG2_TAPS;
  localparam int ACC_W = DATA_WIDTH + LOG2_TAPS;

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STEADY = 1'b1
  } state_e;

  logic signed [DATA_WIDTH-1:0] samples_q [N];
  logic        [LOG2_TAPS-1:0]  wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic        [LOG2_TAPS-1:0]  count_q, count_d;
  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         primed_q, primed_d;

  logic signed [DATA_WIDTH-1:0] oldest_s;
  logic signed [ACC_W-1:0]      new_ext_s;
  logic signed [ACC_W-1:0]      old_ext_s;
  logic signed [ACC_W-1:0]      acc_sum_s;
  logic signed [ACC_W-1:0]      mean_full_s;

  // Datapath and FSM next-state: running sum update, pointer advance, output mean.
  always_comb begin
    // The slot about to be overwritten holds the oldest sample; reading it
    // here is the read half of the same-cycle read-before-write.
    oldest_s    = samples_q[wr_ptr_q];
    new_ext_s   = {{LOG2_TAPS{bus.i_data[DATA_WIDTH-1]}}, bus.i_data};
    old_ext_s   = {{LOG2_TAPS{oldest_s[DATA_WIDTH-1]}}, oldest_s};
    // Intermediate add may wrap, but the final sum always fits ACC_W bits,
    // so modular arithmetic yields the exact result.
    acc_sum_s   = acc_q + new_ext_s - old_ext_s;
    // Arithmetic shift floors toward minus infinity; result fits DATA_WIDTH.
    mean_full_s = acc_sum_s >>> LOG2_TAPS;

    acc_d    = acc_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    state_d  = state_q;
    count_d  = count_q;
    primed_d = primed_q;

    if (bus.i_valid) begin
      acc_d    = acc_sum_s;
      wr_ptr_d = wr_ptr_q + LOG2_TAPS'(1);
      data_d   = mean_full_s[DATA_WIDTH-1:0];
      valid_d  = 1'b1;
    end else begin
      acc_d    = acc_q;
      wr_ptr_d = wr_ptr_q;
      data_d   = data_q;
      valid_d  = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (bus.i_valid) begin
          if (count_q == LOG2_TAPS'(N - 1)) begin
            // N-th sample: window is full, primed rises with its o_valid.
            state_d  = ST_STEADY;
            primed_d = 1'b1;
          end else begin
            count_d  = count_q + LOG2_TAPS'(1);
          end
        end else begin
          count_d = count_q;
        end
      end
      ST_STEADY: begin
        primed_d = 1'b1;
      end
      default: begin
        state_d  = ST_FILL;
        count_d  = '0;
        primed_d = 1'b0;
      end
    endcase
  end

  // State, output and sample-buffer registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N; i++) begin
        samples_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      state_q  <= ST_FILL;
      data_q   <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      if (bus.i_valid) begin
        samples_q[wr_ptr_q] <= bus.i_data;
      end
      wr_ptr_q <= wr_ptr_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_primed = primed_q;

endmodule

// File: tb/tb_moving_average.sv
module tb_moving_average;

  logic i_clk;
  logic i_reset_n;
  int   n_cmp;
  int   n_bad;
  int   pulses;

  moving_average_if #(.DATA_WIDTH(8)) bus ();

  moving_average #(
    .DATA_WIDTH (8),
    .LOG2_TAPS  (3)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 time unit after rise.
  task automatic step(input logic v, input int x);
    @(negedge i_clk);
    bus.i_valid = v;
    bus.i_data  = 8'(x);
    @(posedge i_clk);
    #1;
    if (bus.o_valid === 1'b1) pulses++;
  endtask

  task automatic expect_out(input string tag, input int d, input logic v, input logic p);
    check_eq({tag, ".data"},   $signed(bus.o_data), d);
    check_eq({tag, ".valid"},  {31'd0, bus.o_valid}, {31'd0, v});
    check_eq({tag, ".primed"}, {31'd0, bus.o_primed}, {31'd0, p});
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'sd0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // Eight samples of 16 from an empty window: 2,4,...,16, primed on the 8th.
  task automatic ramp16(input string tag);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 16);
      expect_out($sformatf("%s[%0d]", tag, k), 2 * k, 1'b1, (k == 8));
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    pulses      = 0;
    i_reset_n   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'sd0;

    // Reset state
    do_reset();
    step(1'b0, 0);
    expect_out("reset", 0, 1'b0, 1'b0);

    // T1 ramp
    do_reset();
    ramp16("t1");
    step(1'b0, 0);
    expect_out("t1.idle", 16, 1'b0, 1'b1);

    // T2 negative full scale
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, -128);
      expect_out($sformatf("t2[%0d]", k), (k <= 8) ? -16 * k : -128, 1'b1, (k >= 8));
    end

    // T3 alternating +127/-128; sums 127,-1,126,-2,125,-3,124,-4 then -4
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      int exp_d;
      exp_d = ((k % 2) == 1 && k < 8) ? 15 : -1;
      step(1'b1, ((k % 2) == 1) ? 127 : -128);
      expect_out($sformatf("t3[%0d]", k), exp_d, 1'b1, (k >= 8));
    end

    // T4 gaps: 8,8,_,_,8
    do_reset();
    pulses = 0;
    step(1'b1, 8);  expect_out("t4.s1", 1, 1'b1, 1'b0);
    step(1'b1, 8);  expect_out("t4.s2", 2, 1'b1, 1'b0);
    step(1'b0, 99); expect_out("t4.g1", 2, 1'b0, 1'b0);
    step(1'b0, 99); expect_out("t4.g2", 2, 1'b0, 1'b0);
    step(1'b1, 8);  expect_out("t4.s3", 3, 1'b1, 1'b0);
    step(1'b0, 0);  expect_out("t4.g3", 3, 1'b0, 1'b0);
    check_eq("t4.pulses", pulses, 3);

    // T5 wrap: 10 x 8 then 8 x 0
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 8);
      expect_out($sformatf("t5.a[%0d]", k), (k <= 8) ? k : 8, 1'b1, (k >= 8));
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 0);
      expect_out($sformatf("t5.b[%0d]", k), 8 - k, 1'b1, 1'b1);
    end

    // T6 reset mid-window with i_valid held high
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 16);
    end
    expect_out("t6.pre", 10, 1'b1, 1'b0);
    @(negedge i_clk);
    i_reset_n   = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'sd16;
    @(posedge i_clk);
    #1;
    expect_out("t6.rst", 0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_reset_n   = 1'b1;
    bus.i_valid = 1'b0;
    ramp16("t6.ramp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
